// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_fsm
// Purpose  : Cache miss fill controller. Requests an 8-word block from main
//            memory, writes each returned word into the data array and
//            installs the tag once the last word has arrived.
// Options  : CACHE_FILL_CRITICAL_WORD_FIRST_EN - start the burst at the
//            missing word and wrap, instead of always starting at word 0.
// Revision : 1.0 - initial release
// ============================================================================
module cache_fill_fsm (
   input  logic        clk,
   input  logic        rst,
   input  logic        miss_detected,
   input  logic [15:0] miss_address,
   input  logic        mem_data_valid,
   input  logic [15:0] mem_data,
   output logic        fsm_busy,
   output logic        mem_en,
   output logic [15:0] memory_address,
   output logic        write_data_array,
   output logic [15:0] fill_word_addr,
   output logic [15:0] fill_data,
   output logic        write_tag_array
);

   localparam logic [0:0] c_IDLE        = 1'b0;
   localparam logic [0:0] c_FILL        = 1'b1;
   localparam logic [3:0] c_BLOCK_WORDS = 4'd8;
   localparam logic [3:0] c_LAST_WORD   = 4'd7;

   logic [0:0]  r_state;
   logic [3:0]  r_issue_cnt;
   logic [3:0]  r_recv_cnt;
   logic [15:0] r_miss_addr;

   logic        w_in_fill;
   logic        w_issue;
   logic        w_recv;
   logic        w_last;
   logic [11:0] w_base;
   logic [2:0]  w_issue_off;
   logic [2:0]  w_recv_off;
   logic        w_unused;

   assign w_in_fill = (r_state == c_FILL);
   assign w_base    = r_miss_addr[15:4];
   assign w_issue   = w_in_fill && (r_issue_cnt < c_BLOCK_WORDS);
   assign w_recv    = w_in_fill && mem_data_valid;
   assign w_last    = w_recv && (r_recv_cnt == c_LAST_WORD);

   // Low address bits only matter for word ordering, never for the block base.
   assign w_unused  = ^{miss_address[3:0], r_miss_addr[3:0]};

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
   assign w_issue_off = r_miss_addr[3:1] + r_issue_cnt[2:0];
   assign w_recv_off  = r_miss_addr[3:1] + r_recv_cnt[2:0];
`else
   assign w_issue_off = r_issue_cnt[2:0];
   assign w_recv_off  = r_recv_cnt[2:0];
`endif

   assign fsm_busy         = w_in_fill | miss_detected;
   assign mem_en           = w_issue;
   assign memory_address   = w_in_fill ? {w_base, w_issue_off, 1'b0} : 16'h0000;
   assign write_data_array = w_recv;
   assign fill_word_addr   = w_in_fill ? {w_base, w_recv_off, 1'b0} : 16'h0000;
   assign fill_data        = w_in_fill ? mem_data : 16'h0000;
   assign write_tag_array  = w_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_IDLE;
         r_issue_cnt <= 4'd0;
         r_recv_cnt  <= 4'd0;
         r_miss_addr <= 16'h0000;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (miss_detected) begin
                  r_state     <= c_FILL;
                  r_miss_addr <= miss_address;
                  r_issue_cnt <= 4'd0;
                  r_recv_cnt  <= 4'd0;
               end
            end
            c_FILL: begin
               if (w_issue) begin
                  r_issue_cnt <= r_issue_cnt + 4'd1;
               end
               if (w_recv) begin
                  r_recv_cnt <= r_recv_cnt + 4'd1;
               end
               if (w_last) begin
                  r_state <= c_IDLE;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_fill_fsm
// Purpose  : Directed bench for cache_fill_fsm with a 4-cycle memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_fill_fsm;

   logic        clk;
   logic        rst;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        mem_data_valid;
   logic [15:0] mem_data;
   logic        fsm_busy;
   logic        mem_en;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic [15:0] fill_word_addr;
   logic [15:0] fill_data;
   logic        write_tag_array;

   // memory model vs. manually forced return path
   logic        mem_manual;
   logic        man_valid;
   logic [15:0] man_data;
   logic        mdl_valid;
   logic [15:0] mdl_data;

   assign mem_data_valid = mem_manual ? man_valid : mdl_valid;
   assign mem_data       = mem_manual ? man_data  : mdl_data;

   int n_checks;
   int n_fail;

   // monitor state
   int          clr_req;
   int          clr_seen;
   int          mon_cyc;
   int          busy_cnt;
   int          n_req;
   int          n_wr;
   int          n_tag;
   int          tag_idx;
   logic [15:0] req_a [16];
   int          req_c [16];
   logic [15:0] wr_a  [16];
   logic [15:0] wr_d  [16];

   cache_fill_fsm dut (
      .clk              (clk),
      .rst              (rst),
      .miss_detected    (miss_detected),
      .miss_address     (miss_address),
      .mem_data_valid   (mem_data_valid),
      .mem_data         (mem_data),
      .fsm_busy         (fsm_busy),
      .mem_en           (mem_en),
      .memory_address   (memory_address),
      .write_data_array (write_data_array),
      .fill_word_addr   (fill_word_addr),
      .fill_data        (fill_data),
      .write_tag_array  (write_tag_array)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Memory: a request seen in cycle k returns valid data in cycle k+4.
   initial begin
      logic [3:0]  dly_v;
      logic [15:0] dly_a [4];
      logic        cap_v;
      logic [15:0] cap_a;
      dly_v     = 4'b0;
      for (int i = 0; i < 4; i++) dly_a[i] = 16'h0;
      mdl_valid = 1'b0;
      mdl_data  = 16'h0;
      forever begin
         @(negedge clk);
         cap_v = (mem_en === 1'b1);
         cap_a = memory_address;
         @(posedge clk);
         #1;
         dly_v    = {dly_v[2:0], cap_v};
         dly_a[3] = dly_a[2];
         dly_a[2] = dly_a[1];
         dly_a[1] = dly_a[0];
         dly_a[0] = cap_a;
         mdl_valid = dly_v[3];
         mdl_data  = dly_v[3] ? (dly_a[3] ^ 16'h5A5A) : 16'h0000;
      end
   end

   initial begin
      clr_seen = 0;
      mon_cyc  = 0;
      busy_cnt = 0;
      n_req    = 0;
      n_wr     = 0;
      n_tag    = 0;
      tag_idx  = -1;
      forever begin
         @(negedge clk);
         if (clr_seen != clr_req) begin
            clr_seen = clr_req;
            busy_cnt = 0;
            n_req    = 0;
            n_wr     = 0;
            n_tag    = 0;
            tag_idx  = -1;
         end
         mon_cyc++;
         if (fsm_busy === 1'b1) busy_cnt++;
         if (mem_en === 1'b1) begin
            if (n_req < 16) begin
               req_a[n_req] = memory_address;
               req_c[n_req] = mon_cyc;
            end
            n_req++;
         end
         if (write_data_array === 1'b1) begin
            if (n_wr < 16) begin
               wr_a[n_wr] = fill_word_addr;
               wr_d[n_wr] = fill_data;
            end
            if (write_tag_array === 1'b1) tag_idx = n_wr;
            n_wr++;
         end
         if (write_tag_array === 1'b1) n_tag++;
      end
   end

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_mon();
      clr_req++;
   endtask

   function automatic logic [127:0] exp_block(input logic [15:0] a);
      logic [2:0]   first;
      logic [2:0]   off;
      logic [127:0] r;
      first = 3'd0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      first = a[3:1];
`endif
      r = '0;
      for (int i = 0; i < 8; i++) begin
         off = first + 3'(i);
         r[i*16 +: 16] = {a[15:4], off, 1'b0};
      end
      return r;
   endfunction

   task automatic check_idle(input string tag);
      @(negedge clk);
      check_value({tag, " busy"},     {31'b0, fsm_busy},         32'd0);
      check_value({tag, " mem_en"},   {31'b0, mem_en},           32'd0);
      check_value({tag, " mem_addr"}, {16'b0, memory_address},   32'd0);
      check_value({tag, " fill_adr"}, {16'b0, fill_word_addr},   32'd0);
      check_value({tag, " wr_data"},  {31'b0, write_data_array}, 32'd0);
      check_value({tag, " wr_tag"},   {31'b0, write_tag_array},  32'd0);
   endtask

   // Starts a miss in the current cycle; returns at the start of the first IDLE cycle.
   task automatic run_fill(input string tag, input logic [15:0] addr, input logic [127:0] exp);
      int   t0;
      logic done;
      clear_mon();
      miss_detected = 1'b1;
      miss_address  = addr;
      @(negedge clk);
      check_value({tag, " busy@detect"},   {31'b0, fsm_busy}, 32'd1);
      check_value({tag, " mem_en@detect"}, {31'b0, mem_en},   32'd0);
      #1;
      t0 = mon_cyc;
      next();
      miss_address = addr ^ 16'h0100;
      done = 1'b0;
      for (int g = 0; g < 30 && !done; g++) begin
         @(negedge clk);
         if (write_tag_array === 1'b1) done = 1'b1;
         else next();
      end
      #1;
      check_value({tag, " completion"}, {31'b0, done}, 32'd1);
      check_value({tag, " n_req"}, n_req, 32'd8);
      check_value({tag, " n_wr"},  n_wr,  32'd8);
      for (int i = 0; i < 8; i++) begin
         check_value($sformatf("%s req%0d", tag, i), {16'b0, req_a[i]}, {16'b0, exp[i*16 +: 16]});
         check_value($sformatf("%s wadr%0d", tag, i), {16'b0, wr_a[i]}, {16'b0, exp[i*16 +: 16]});
         check_value($sformatf("%s wdat%0d", tag, i), {16'b0, wr_d[i]}, {16'b0, exp[i*16 +: 16] ^ 16'h5A5A});
      end
      check_value({tag, " first_req_cyc"}, req_c[0], t0 + 1);
      check_value({tag, " last_req_cyc"},  req_c[7], t0 + 8);
      check_value({tag, " n_tag"},   n_tag,   32'd1);
      check_value({tag, " tag_idx"}, tag_idx, 32'd7);
      check_value({tag, " busy_len"}, busy_cnt, 32'd13);
      next();
      miss_detected = 1'b0;
      miss_address  = 16'h0000;
   endtask

   initial begin
      logic [127:0] blk_1236;
      n_checks      = 0;
      n_fail        = 0;
      clr_req       = 0;
      rst           = 1'b1;
      miss_detected = 1'b0;
      miss_address  = 16'h0000;
      mem_manual    = 1'b0;
      man_valid     = 1'b0;
      man_data      = 16'h0000;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      blk_1236 = {16'h1234, 16'h1232, 16'h1230, 16'h123E,
                  16'h123C, 16'h123A, 16'h1238, 16'h1236};
`else
      blk_1236 = {16'h123E, 16'h123C, 16'h123A, 16'h1238,
                  16'h1236, 16'h1234, 16'h1232, 16'h1230};
`endif

      // reset state, busy follows miss_detected, reset wins over a miss
      next();
      check_idle("reset");
      check_value("reset fill_data", {16'b0, fill_data}, 32'd0);
      next();
      miss_detected = 1'b1;
      miss_address  = 16'h4444;
      @(negedge clk);
      check_value("reset busy_follows_miss", {31'b0, fsm_busy}, 32'd1);
      next();
      miss_detected = 1'b0;
      check_idle("reset_priority");
      next();
      rst = 1'b0;
      check_idle("post_reset");

      // stray memory returns while idle
      next();
      mem_manual = 1'b1;
      man_valid  = 1'b1;
      man_data   = 16'hBEEF;
      for (int i = 0; i < 3; i++) begin
         check_idle($sformatf("idle_valid%0d", i));
         next();
      end
      mem_manual = 1'b0;
      man_valid  = 1'b0;
      man_data   = 16'h0000;

      run_fill("miss1236", 16'h1236, blk_1236);
      check_idle("after1236");
      next();

      run_fill("missFFFE", 16'hFFFE, exp_block(16'hFFFE));
      check_idle("afterFFFE");
      next();

      // back-to-back misses with no dead cycle
      run_fill("b2b_0000", 16'h0000, exp_block(16'h0000));
      run_fill("b2b_0100", 16'h0100, exp_block(16'h0100));
      check_idle("after_b2b");
      next();

      // reset in FILL cycle 6 aborts the fill
      miss_detected = 1'b1;
      miss_address  = 16'h2000;
      next();
      miss_detected = 1'b0;
      for (int i = 0; i < 5; i++) next();
      rst = 1'b1;
      next();
      rst = 1'b0;
      clear_mon();
      check_idle("abort");
      for (int i = 0; i < 10; i++) next();
      @(negedge clk);
      #1;
      check_value("abort late_writes", n_wr,  32'd0);
      check_value("abort tag_pulses",  n_tag, 32'd0);
      check_value("abort requests",    n_req, 32'd0);
      next();

      run_fill("refill1236", 16'h1236, blk_1236);
      check_idle("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port miss_detected, input, 1, cache tag lookup missed this cycle.
REQ-004 SHALL have port miss_address, input, 16, byte address of the missing access.
REQ-005 SHALL have port mem_data_valid, input, 1, main memory returns a word this cycle.
REQ-006 SHALL have port mem_data, input, 16, word returned by main memory.
REQ-007 SHALL have port fsm_busy, output, 1, pipeline stall request (drives cache busy).
REQ-008 SHALL have port mem_en, output, 1, main memory read request this cycle.
REQ-009 SHALL have port memory_address, output, 16, address of the current memory request.
REQ-010 SHALL have port write_data_array, output, 1, write fill_data into the data array at fill_word_addr.
REQ-011 SHALL have port fill_word_addr, output, 16, data-array address of the word being written.
REQ-012 SHALL have port fill_data, output, 16, word to write; equals mem_data.
REQ-013 SHALL have port write_tag_array, output, 1, one-cycle pulse to install the tag and set valid.

Function
REQ-014 SHALL implement two states, IDLE and FILL; block = 8 words of 16 bits (16 bytes), base = latched miss_address[15:4].
REQ-015 IDLE: fsm_busy SHALL equal miss_detected combinationally; mem_en, write_data_array and write_tag_array SHALL be 0.
REQ-016 IDLE with miss_detected=1 SHALL latch miss_address, clear issue_cnt and recv_cnt (4-bit each), and enter FILL at the next edge.
REQ-017 FILL: fsm_busy SHALL be 1; miss_detected and miss_address changes SHALL be ignored.
REQ-018 FILL: mem_en SHALL be 1 while issue_cnt<8; memory_address SHALL be {base, issue_off, 1'b0}; issue_cnt SHALL increment each such cycle and saturate at 8.
REQ-019 mem_data_valid in FILL SHALL assert write_data_array the same cycle with fill_word_addr={base, recv_off, 1'b0}; recv_cnt SHALL increment.
REQ-020 mem_data_valid in IDLE SHALL be ignored: no write, no counter change.
REQ-021 The cycle the 8th word arrives (recv_cnt==7 with valid) SHALL also pulse write_tag_array; the FSM SHALL enter IDLE at the next edge, when fsm_busy drops.
REQ-022 A miss_detected in the first IDLE cycle after completion SHALL start a new fill with no dead cycle.
REQ-023 With the 4-cycle memory model (request in cycle k -> valid in cycle k+4), fsm_busy SHALL be high for exactly 13 cycles per miss (detect cycle + 12 FILL cycles).
REQ-024 memory_address and fill_word_addr SHALL be 0 when not in FILL.
REQ-025 Offsets SHALL be 3 bits and wrap modulo 8; the byte bit [0] SHALL always be 0.

Reset
REQ-026 rst SHALL force IDLE, zero both counters and the latched address, and take priority over all inputs.
REQ-027 Reset during FILL SHALL abort the fill: no write_tag_array pulse, and any later mem_data_valid is ignored.
REQ-028 After reset, all outputs SHALL be 0 except fsm_busy, which follows miss_detected.

Configuration
REQ-029 Macro CACHE_FILL_CRITICAL_WORD_FIRST_EN defined: issue_off = (miss_word + issue_cnt) mod 8 and recv_off = (miss_word + recv_cnt) mod 8, where miss_word = miss_address[3:1].
REQ-030 Macro absent: issue_off = issue_cnt[2:0] and recv_off = recv_cnt[2:0], so fill order is always word 0 through 7.
REQ-031 Completion timing, busy length and the tag pulse SHALL be identical in both builds.

Verification
REQ-032 Miss at 0x1236, macro off, 4-cycle memory -> memory_address 0x1230, 0x1232 ... 0x123E on 8 consecutive cycles; 8 data writes in the same order; write_tag_array with the 8th write; busy 13 cycles.
REQ-033 Same miss with macro on -> requests 0x1236, 0x1238, 0x123A, 0x123C, 0x123E, 0x1230, 0x1232, 0x1234; writes in matching order.
REQ-034 Miss at 0xFFFE -> base 0xFFF; addresses stay within 0xFFF0-0xFFFE; no carry into bit 16.
REQ-035 rst asserted in FILL cycle 6 -> IDLE next cycle; late valids cause no write_data_array; write_tag_array never pulses.
REQ-036 Back-to-back misses at 0x0000 and 0x0100, the second asserted the cycle after completion -> second fill starts immediately; miss_address changes during the first fill are ignored.
REQ-037 mem_data_valid=1 with mem_data=0xBEEF in IDLE -> write_data_array stays 0; counters unchanged.
